// File: rtl/hash_rmw_update_ctrl.sv
// Read-modify-write controller for a hash table: per-lane XOR updates with a 2-cycle read
// latency, forwarding of in-flight results, and a full-table zero-fill.
module hash_rmw_update_ctrl #(
  parameter int unsigned NUM_MUL     = 4,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned DATA_WIDTH  = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INDEX_WIDTH-1:0]          in_index,
  input  logic [NUM_MUL-1:0]              in_lane_mask,
  input  logic [NUM_MUL*DATA_WIDTH-1:0]   in_data,
  output logic [INDEX_WIDTH-1:0]          rd_index,
  input  logic [NUM_MUL*DATA_WIDTH-1:0]   rd_out_update,
  output logic                            write_reg_11_valid,
  output logic [INDEX_WIDTH-1:0]          write_reg_11_index,
  output logic [NUM_MUL*DATA_WIDTH-1:0]   write_reg_11_xor,
  output logic [NUM_MUL-1:0]              arbiter_result,
  input  logic                            start_clear,
  output logic                            clear_done
);

  localparam int unsigned LineWidth = NUM_MUL * DATA_WIDTH;
  localparam int unsigned HistDepth = 3;
  localparam logic [INDEX_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {StRun, StDrain, StClear} state_e;

  state_e state_q, state_d;
  logic   accept;

  logic                   s1_valid_q, s2_valid_q;
  logic [INDEX_WIDTH-1:0] s1_index_q, s2_index_q;
  logic [NUM_MUL-1:0]     s1_mask_q, s2_mask_q;
  logic [LineWidth-1:0]   s1_data_q, s2_data_q;

  // Entry 0 is the newest completed op; it always mirrors the output register when valid.
  logic                   hist_valid_q [HistDepth];
  logic [INDEX_WIDTH-1:0] hist_index_q [HistDepth];
  logic [NUM_MUL-1:0]     hist_mask_q  [HistDepth];
  logic [LineWidth-1:0]   hist_data_q  [HistDepth];

  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic                   clear_fire, clear_last;
  logic [LineWidth-1:0]   result;

  assign in_ready = (state_q == StRun) && !start_clear;
  assign accept   = in_valid && in_ready;
  assign rd_index = accept ? in_index : '0;

  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_MUL; i++) begin
      logic [DATA_WIDTH-1:0] prior;
      prior = rd_out_update[i*DATA_WIDTH +: DATA_WIDTH];
      // Oldest first so the newest matching entry wins.
      for (int j = HistDepth - 1; j >= 0; j--) begin
        if (hist_valid_q[j] && hist_index_q[j] == s2_index_q && hist_mask_q[j][i]) begin
          prior = hist_data_q[j][i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      result[i*DATA_WIDTH +: DATA_WIDTH] =
          s2_mask_q[i] ? (prior ^ s2_data_q[i*DATA_WIDTH +: DATA_WIDTH]) : prior;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clear_fire = 1'b0;
    clear_last = 1'b0;
    case (state_q)
      StRun: begin
        if (start_clear) state_d = StDrain;
      end
      StDrain: begin
        if (!s1_valid_q && !s2_valid_q) state_d = StClear;
      end
      StClear: begin
        // The cycle after the final write carries the clear_done pulse; RUN follows it.
        if (clear_done) begin
          state_d = StRun;
        end else begin
          clear_fire = 1'b1;
          if (cnt_q == CntMax) begin
            clear_last = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StClear;
      cnt_q      <= '0;
      clear_done <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_index_q <= '0;
      s1_mask_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_index_q <= '0;
      s2_mask_q  <= '0;
      s2_data_q  <= '0;
      write_reg_11_valid <= 1'b0;
      write_reg_11_index <= '0;
      write_reg_11_xor   <= '0;
      arbiter_result     <= '0;
      for (int j = 0; j < HistDepth; j++) begin
        hist_valid_q[j] <= 1'b0;
        hist_index_q[j] <= '0;
        hist_mask_q[j]  <= '0;
        hist_data_q[j]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clear_done <= clear_last;

      s1_valid_q <= accept;
      if (accept) begin
        s1_index_q <= in_index;
        s1_mask_q  <= in_lane_mask;
        s1_data_q  <= in_data;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_index_q <= s1_index_q;
        s2_mask_q  <= s1_mask_q;
        s2_data_q  <= s1_data_q;
      end

      write_reg_11_valid <= clear_fire || s2_valid_q;
      if (clear_fire) begin
        write_reg_11_index <= cnt_q;
        write_reg_11_xor   <= '0;
        arbiter_result     <= '1;
      end else if (s2_valid_q) begin
        write_reg_11_index <= s2_index_q;
        write_reg_11_xor   <= result;
        arbiter_result     <= s2_mask_q;
      end else begin
        arbiter_result <= '0;
      end

      if (clear_last) begin
        for (int j = 0; j < HistDepth; j++) hist_valid_q[j] <= 1'b0;
      end else if (s2_valid_q) begin
        for (int j = HistDepth - 1; j > 0; j--) begin
          hist_valid_q[j] <= hist_valid_q[j-1];
          hist_index_q[j] <= hist_index_q[j-1];
          hist_mask_q[j]  <= hist_mask_q[j-1];
          hist_data_q[j]  <= hist_data_q[j-1];
        end
        hist_valid_q[0] <= 1'b1;
        hist_index_q[0] <= s2_index_q;
        hist_mask_q[0]  <= s2_mask_q;
        hist_data_q[0]  <= result;
      end
    end
  end

endmodule

// File: tb/tb_hash_rmw_update_ctrl.sv
// Directed bench for hash_rmw_update_ctrl with a 2-cycle-latency table model.
module tb_hash_rmw_update_ctrl;

  localparam int NumVec = 16;

  logic         clk, reset;
  logic         in_valid, in_ready;
  logic [11:0]  in_index;
  logic [3:0]   in_lane_mask;
  logic [255:0] in_data;
  logic [11:0]  rd_index;
  logic [255:0] rd_out_update;
  logic         write_reg_11_valid;
  logic [11:0]  write_reg_11_index;
  logic [255:0] write_reg_11_xor;
  logic [3:0]   arbiter_result;
  logic         start_clear, clear_done;

  int checks = 0;
  int errors = 0;

  hash_rmw_update_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_index           (in_index),
    .in_lane_mask       (in_lane_mask),
    .in_data            (in_data),
    .rd_index           (rd_index),
    .rd_out_update      (rd_out_update),
    .write_reg_11_valid (write_reg_11_valid),
    .write_reg_11_index (write_reg_11_index),
    .write_reg_11_xor   (write_reg_11_xor),
    .arbiter_result     (arbiter_result),
    .start_clear        (start_clear),
    .clear_done         (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table model: read data appears two cycles after rd_index, writes are lane-masked.
  logic [255:0] mem [4096];
  logic [255:0] rd_p1, rd_p2;
  assign rd_out_update = rd_p2;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {4{64'hDEAD_BEEF_0BAD_F00D}};
  end

  always @(posedge clk) begin
    rd_p1 <= mem[rd_index];
    rd_p2 <= rd_p1;
    if (write_reg_11_valid) begin
      for (int l = 0; l < 4; l++) begin
        if (arbiter_result[l]) mem[write_reg_11_index][l*64 +: 64] <= write_reg_11_xor[l*64 +: 64];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic         v;
    logic [11:0]  idx;
    logic [3:0]   mask;
    logic [255:0] data;
    logic         ev;
    logic [3:0]   emask;
    logic [255:0] edata;
  } vec_t;

  vec_t vecs [NumVec];

  function automatic logic [255:0] ln(input logic [63:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic vec_t op(input logic [11:0] idx, input logic [3:0] mask,
                              input logic [255:0] data, input logic [255:0] edata);
    vec_t r;
    r.v = 1'b1; r.idx = idx; r.mask = mask; r.data = data;
    r.ev = 1'b1; r.emask = mask; r.edata = edata;
    return r;
  endfunction

  function automatic vec_t bubble();
    return '0;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] idx, input logic [3:0] mask,
                       input logic [255:0] data);
    in_valid = v; in_index = idx; in_lane_mask = mask; in_data = data;
  endtask

  task automatic run_clear(input string name);
    int  writes = 0;
    int  bad    = 0;
    bit  got    = 0;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clk);
      if (in_ready) bad++;
      if (write_reg_11_valid) begin
        if (write_reg_11_index != 12'(writes) || arbiter_result != 4'hF ||
            write_reg_11_xor != '0) bad++;
        writes++;
      end
      if (clear_done) got = 1;
    end
    check({name, "_write_count"}, 256'(writes), 256'd4096);
    check({name, "_write_content"}, 256'(bad), 256'd0);
    check({name, "_done_seen"}, 256'(got), 256'd1);
    @(negedge clk);
    check({name, "_done_single"}, 256'(clear_done), 256'd0);
    check({name, "_ready_after"}, 256'(in_ready), 256'd1);
  endtask

  initial begin
    reset = 1'b0; start_clear = 1'b0;
    drive(1'b0, '0, '0, '0);

    vecs[0]  = op(12'd5, 4'b0001, ln(0, 0, 0, 64'hA5), ln(0, 0, 0, 64'hA5));
    vecs[1]  = bubble();
    vecs[2]  = op(12'd7, 4'b0010, ln(0, 0, 1, 0), ln(0, 0, 1, 0));
    vecs[3]  = op(12'd7, 4'b0010, ln(0, 0, 2, 0), ln(0, 0, 3, 0));
    vecs[4]  = op(12'd7, 4'b0010, ln(0, 0, 4, 0), ln(0, 0, 7, 0));
    vecs[5]  = op(12'd9, 4'b0011, ln(0, 0, 1, 1), ln(0, 0, 1, 1));
    vecs[6]  = op(12'd9, 4'b0110, ln(0, 2, 2, 0), ln(0, 2, 3, 1));
    vecs[7]  = bubble();
    vecs[8]  = bubble();
    vecs[9]  = bubble();
    vecs[10] = op(12'd5, 4'b0001, ln(0, 0, 0, 64'h0F), ln(0, 0, 0, 64'hAA));
    vecs[11] = op(12'd9, 4'b1000, ln(64'hFFFF, 0, 0, 0), ln(64'hFFFF, 2, 3, 1));
    vecs[12] = op(12'd9, 4'b0100, ln(0, 1, 0, 0), ln(64'hFFFF, 3, 3, 1));
    vecs[13] = op(12'd7, 4'b0000, ln(5, 5, 5, 5), ln(0, 0, 7, 0));
    vecs[14] = bubble();
    vecs[15] = bubble();

    repeat (3) @(negedge clk);
    check("reset_outputs",
          256'({in_ready, write_reg_11_valid, arbiter_result, write_reg_11_index, clear_done}),
          256'd0);
    check("reset_xor", write_reg_11_xor, '0);
    reset = 1'b1;
    run_clear("post_reset");

    for (int k = 0; k < NumVec + 3; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        check($sformatf("vec%0d_valid", k - 3), 256'(write_reg_11_valid), 256'(vecs[k-3].ev));
        check($sformatf("vec%0d_mask", k - 3), 256'(arbiter_result), 256'(vecs[k-3].emask));
        if (vecs[k-3].ev) begin
          check($sformatf("vec%0d_index", k - 3), 256'(write_reg_11_index),
                256'(vecs[k-3].idx));
          check($sformatf("vec%0d_data", k - 3), write_reg_11_xor, vecs[k-3].edata);
        end
      end
      if (k < NumVec) drive(vecs[k].v, vecs[k].idx, vecs[k].mask, vecs[k].data);
      else drive(1'b0, '0, '0, '0);
      #1;
      check($sformatf("rd_index_%0d", k), 256'(rd_index),
            (k < NumVec && vecs[k].v) ? 256'(vecs[k].idx) : 256'd0);
    end

    // Clear requested with two ops in flight.
    @(negedge clk); drive(1'b1, 12'd5, 4'b0001, ln(0, 0, 0, 1));
    @(negedge clk); drive(1'b1, 12'd7, 4'b0010, ln(0, 0, 1, 0));
    @(negedge clk); drive(1'b1, 12'd11, 4'b1111, ln(9, 9, 9, 9)); start_clear = 1'b1;
    #1;
    check("clr_ready_drop", 256'(in_ready), 256'd0);
    check("clr_rd_index_idle", 256'(rd_index), 256'd0);
    @(negedge clk); drive(1'b0, '0, '0, '0); start_clear = 1'b0;
    check("clr_op1_valid", 256'(write_reg_11_valid), 256'd1);
    check("clr_op1_index", 256'(write_reg_11_index), 256'd5);
    check("clr_op1_data", write_reg_11_xor, ln(0, 0, 0, 64'hAB));
    @(negedge clk);
    check("clr_op2_index", 256'(write_reg_11_index), 256'd7);
    check("clr_op2_data", write_reg_11_xor, ln(0, 0, 6, 0));
    check("clr_op2_mask", 256'(arbiter_result), 256'b0010);
    run_clear("mid_traffic");

    drive(1'b1, 12'd5, 4'b0001, '0);
    @(negedge clk); drive(1'b1, 12'd7, 4'b0010, '0);
    @(negedge clk); drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("readback5_index", 256'(write_reg_11_index), 256'd5);
    check("readback5_data", write_reg_11_xor, '0);
    @(negedge clk);
    check("readback7_index", 256'(write_reg_11_index), 256'd7);
    check("readback7_data", write_reg_11_xor, '0);

    // Reset one cycle after an accept.
    @(negedge clk); drive(1'b1, 12'd100, 4'hF, {4{64'h1234}});
    @(negedge clk); drive(1'b0, '0, '0, '0); reset = 1'b0;
    #1;
    check("rst_mid_valid", 256'(write_reg_11_valid), 256'd0);
    check("rst_mid_ready", 256'(in_ready), 256'd0);
    repeat (2) @(negedge clk);
    check("rst_mid_outputs", 256'({write_reg_11_valid, arbiter_result, clear_done}), 256'd0);
    reset = 1'b1;
    run_clear("reset_mid_pipe");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_rmw_update_ctrl.md
HASH_RMW_UPDATE_CTRL -- requirements
Module: hash_rmw_update_ctrl

Interface
REQ-001 SHALL have parameter NUM_MUL, default 4, meaning lanes per hash-table entry.
REQ-002 SHALL have parameter INDEX_WIDTH, default 12, meaning table address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, meaning bits per lane.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  an update request is present.
REQ-007 SHALL have port in_ready  output  1  the request is accepted this cycle.
REQ-008 SHALL have port in_index  input  INDEX_WIDTH  the entry to update.
REQ-009 SHALL have port in_lane_mask  input  NUM_MUL  the lanes to update.
REQ-010 SHALL have port in_data  input  NUM_MUL*DATA_WIDTH  XOR operand; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port rd_index  output  INDEX_WIDTH  table read address.
REQ-012 SHALL have port rd_out_update  input  NUM_MUL*DATA_WIDTH  table read data, valid exactly 2 cycles after rd_index.
REQ-013 SHALL have port write_reg_11_valid  output  1  table write port enable.
REQ-014 SHALL have port write_reg_11_index  output  INDEX_WIDTH  table write address.
REQ-015 SHALL have port write_reg_11_xor  output  NUM_MUL*DATA_WIDTH  table write data.
REQ-016 SHALL have port arbiter_result  output  NUM_MUL  per-lane write enable.
REQ-017 SHALL have port start_clear  input  1  request a zero-fill of the whole table.
REQ-018 SHALL have port clear_done  output  1  single-cycle pulse when the zero-fill completes.

Function
REQ-019 SHALL implement FSM states RUN, DRAIN, CLEAR; reset enters CLEAR.
REQ-020 SHALL, in RUN, drive in_ready=1; an accept occurs when in_valid && in_ready.
REQ-021 SHALL, on an accept at cycle t, drive rd_index=in_index combinationally in cycle t and capture index, mask and data into a 3-stage pipeline.
REQ-022 SHALL, at cycle t+2, form each lane's prior value P from rd_out_update, subject to forwarding (REQ-024).
REQ-023 SHALL, at cycle t+3, register outputs: write_reg_11_valid=1, write_reg_11_index=op index, arbiter_result=op mask, lane data = P xor in_data for masked lanes and P for unmasked lanes.
REQ-024 SHALL, per lane, replace the memory value with the write data of the newest of the previous 3 accepted ops having the same index and that lane's mask bit set; with no match, the memory value is used.
REQ-025 SHALL produce sustained throughput of 1 op/cycle, including back-to-back ops to the same index.
REQ-026 SHALL hold write_reg_11_valid=0 and arbiter_result=0 in cycles with no op at the output stage; pipeline bubbles do not populate the forwarding history.
REQ-027 SHALL, in RUN, on start_clear=1, drop in_ready in the same cycle and enter DRAIN.
REQ-028 SHALL remain in DRAIN until the pipeline and forwarding history are empty (at most 4 cycles), then enter CLEAR.
REQ-029 SHALL, in CLEAR, hold in_ready=0, run a counter from 0 to 2^INDEX_WIDTH-1, and write one index per cycle with write_reg_11_valid=1, arbiter_result all ones and data 0.
REQ-030 SHALL, on the final CLEAR write, pulse clear_done for 1 cycle, clear the forwarding history, and enter RUN on the next cycle.
REQ-031 SHALL ignore start_clear while in DRAIN or CLEAR.
REQ-032 SHALL hold rd_index=0 whenever no accept occurs.

Reset
REQ-033 SHALL, while reset=0, asynchronously force: in_ready=0, write_reg_11_valid=0, arbiter_result=0, write_reg_11_index=0, write_reg_11_xor=0, clear_done=0, clear counter=0, pipeline and history invalid, FSM=CLEAR.
REQ-034 SHALL discard in-flight ops when reset asserts mid-operation, with no write for them after release.
REQ-035 SHALL, after reset release, perform a full clear (2^INDEX_WIDTH writes) before the first in_ready=1.

Verification
REQ-036 SHALL cover post-reset clear: release reset -> 4096 writes of indices 0..4095, data 0, mask 4'hF; clear_done pulses once; in_ready rises on the next cycle.
REQ-037 SHALL cover single update: index 5, mask 4'b0001, lane0 data 64'hA5 on cleared table -> 3 cycles later write index 5, lane0=64'hA5, arbiter_result=4'b0001.
REQ-038 SHALL cover back-to-back hazard: three consecutive ops to index 7, lane1 data 1, 2, 4 -> writes lane1 = 1, 3, 7.
REQ-039 SHALL cover partial-lane forwarding: op A index 9 mask 4'b0011, data 1, then op B index 9 mask 4'b0110, data 2 -> B lane1 = 3, B lane2 = 2 (no forward from A lane2).
REQ-040 SHALL cover clear mid-traffic: start_clear with 2 ops in flight -> both ops write, then the full clear runs, then a read of those indices returns 0.
REQ-041 SHALL cover reset mid-pipeline: reset asserted 1 cycle after an accept -> no write_reg_11_valid for that op; clear restarts at index 0.
